// File: rtl/pong_ball_engine.sv
// Pong ball engine: ball motion, wall/paddle reflection, miss detection,
// score/lives bookkeeping and the registered ball pixel flag.
module pong_ball_engine #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned BALL_SIZE   = 8,
   parameter int unsigned PAD_X       = 630,
   parameter int unsigned PAD_H       = 70,
   parameter int unsigned STEP        = 2,
   parameter int unsigned TICK_DIV    = 416666,
   parameter int unsigned SERVE_TICKS = 60,
   parameter int unsigned LIVES       = 3
) (
   input  logic        vga_clk,
   input  logic        sys_rst_n,
   input  logic        start,
   input  logic [11:0] paddle_y,
   input  logic [11:0] pix_x,
   input  logic [11:0] pix_y,
   output logic [11:0] ball_x,
   output logic [11:0] ball_y,
   output logic        ball_pix,
   output logic        miss,
   output logic [7:0]  score,
   output logic [1:0]  lives,
   output logic [1:0]  state
);
   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned SW = $clog2(SERVE_TICKS + 1);
   localparam logic [11:0] CX = 12'((H_ACTIVE - BALL_SIZE) / 2);
   localparam logic [11:0] CY = 12'((V_ACTIVE - BALL_SIZE) / 2);
   localparam logic [12:0] BS = 13'(BALL_SIZE);
   localparam logic [12:0] ST = 13'(STEP);
   localparam logic [12:0] PX = 13'(PAD_X);
   localparam logic [12:0] PH = 13'(PAD_H);
   localparam logic [12:0] HA = 13'(H_ACTIVE);
   localparam logic [12:0] VA = 13'(V_ACTIVE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      PLAY  = 2'd2,
      OVER  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] tcnt_q;
   logic          tick;
   logic [SW-1:0] scnt_q, scnt_d;
   logic          start_q, rise;
   logic [11:0]   bx_q, bx_d, by_q, by_d;
   logic          dx_q, dx_d, dy_q, dy_d;   // 1 = moving towards larger coordinate
   logic [7:0]    score_q, score_d;
   logic [1:0]    lives_q, lives_d;
   logic          miss_q, miss_d;
   logic          pix_q, pix_d;
   logic [12:0]   bx13, by13, px13, py13, pad13, nx, ny;
   logic          ndx, ndy, hit, miss_now;

   assign tick = (tcnt_q == TW'(TICK_DIV - 1));
   assign rise = start & ~start_q;
   assign bx13  = {1'b0, bx_q};
   assign by13  = {1'b0, by_q};
   assign px13  = {1'b0, pix_x};
   assign py13  = {1'b0, pix_y};
   assign pad13 = {1'b0, paddle_y};

   // Candidate move for the next tick, reflections applied in priority order
   always_comb begin
      nx       = dx_q ? bx13 + ST : bx13 - ST;
      ny       = dy_q ? by13 + ST : by13 - ST;
      ndx      = dx_q;
      ndy      = dy_q;
      hit      = 1'b0;
      miss_now = 1'b0;
      if (!dy_q && by13 < ST) begin
         ny  = '0;
         ndy = 1'b1;
      end
      if (dy_q && ny + BS >= VA) begin
         ny  = VA - BS;
         ndy = 1'b0;
      end
      if (!dx_q && bx13 < ST) begin
         nx  = '0;
         ndx = 1'b1;
      end
      if (dx_q && bx13 + BS < PX && nx + BS >= PX &&
          ny < pad13 + PH && ny + BS > pad13) begin
         nx  = PX - BS;
         ndx = 1'b0;
         hit = 1'b1;
      end
      if (ndx && nx + BS >= HA) miss_now = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      bx_d    = bx_q;
      by_d    = by_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      score_d = score_q;
      lives_d = lives_q;
      miss_d  = 1'b0;
      pix_d   = (state_q != IDLE) &&
                (px13 >= bx13) && (px13 < bx13 + BS) &&
                (py13 >= by13) && (py13 < by13 + BS);
      unique case (state_q)
         IDLE: begin
            bx_d = CX;
            by_d = CY;
            if (rise) begin
               score_d = '0;
               lives_d = 2'(LIVES);
               scnt_d  = '0;
               state_d = SERVE;
            end
         end
         SERVE: begin
            bx_d = CX;
            by_d = CY;
            dx_d = 1'b1;
            dy_d = 1'b1;
            if (!start) begin
               state_d = IDLE;
            end else if (tick) begin
               scnt_d = scnt_q + SW'(1);
               if (scnt_q == SW'(SERVE_TICKS - 1)) state_d = PLAY;
            end
         end
         PLAY: begin
            if (!start) begin
               state_d = IDLE;
               bx_d    = CX;
               by_d    = CY;
            end else if (tick) begin
               if (miss_now) begin
                  miss_d  = 1'b1;
                  bx_d    = CX;
                  by_d    = CY;
                  lives_d = lives_q - 2'd1;
                  scnt_d  = '0;
                  state_d = (lives_q > 2'd1) ? SERVE : OVER;
               end else begin
                  bx_d = nx[11:0];
                  by_d = ny[11:0];
                  dx_d = ndx;
                  dy_d = ndy;
                  if (hit && score_q != 8'hFF) score_d = score_q + 8'd1;
               end
            end
         end
         OVER: begin
            bx_d = CX;
            by_d = CY;
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         tcnt_q  <= '0;
         scnt_q  <= '0;
         start_q <= 1'b0;
         bx_q    <= CX;
         by_q    <= CY;
         dx_q    <= 1'b1;
         dy_q    <= 1'b1;
         score_q <= '0;
         lives_q <= 2'(LIVES);
         miss_q  <= 1'b0;
         pix_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tick ? '0 : tcnt_q + TW'(1);
         scnt_q  <= scnt_d;
         start_q <= start;
         bx_q    <= bx_d;
         by_q    <= by_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         score_q <= score_d;
         lives_q <= lives_d;
         miss_q  <= miss_d;
         pix_q   <= pix_d;
      end
   end

   assign ball_x   = bx_q;
   assign ball_y   = by_q;
   assign ball_pix = pix_q;
   assign miss     = miss_q;
   assign score    = score_q;
   assign lives    = lives_q;
   assign state    = state_q;
endmodule

// File: tb/tb_pong_ball_engine.sv
// Bench for pong_ball_engine: directed game scenarios, a pixel vector table,
// and randomized play checked cycle-by-cycle against a behavioural model.
module tb_pong_ball_engine;
   localparam int TDIV   = 4;
   localparam int CX     = 316;
   localparam int CY     = 236;
   localparam int BS     = 8;
   localparam int STEP   = 2;
   localparam int PAD_X  = 630;
   localparam int PAD_H  = 70;
   localparam int HA     = 640;
   localparam int VA     = 480;
   localparam int NSERVE = 60;
   localparam int NLIVES = 3;

   logic        vga_clk;
   logic        sys_rst_n;
   logic        start;
   logic [11:0] paddle_y, pix_x, pix_y;
   logic [11:0] ball_x, ball_y;
   logic        ball_pix, miss;
   logic [7:0]  score;
   logic [1:0]  lives, state;

   int checks   = 0;
   int failures = 0;

   pong_ball_engine #(.TICK_DIV(TDIV)) dut (
      .vga_clk  (vga_clk),
      .sys_rst_n(sys_rst_n),
      .start    (start),
      .paddle_y (paddle_y),
      .pix_x    (pix_x),
      .pix_y    (pix_y),
      .ball_x   (ball_x),
      .ball_y   (ball_y),
      .ball_pix (ball_pix),
      .miss     (miss),
      .score    (score),
      .lives    (lives),
      .state    (state)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   // Game model: position plus signed velocity, state as 0..3
   typedef struct {
      int st, x, y, vx, vy, score, lives, cnt, serve, start_prev, miss, pix, ticks;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t mreset();
      mdl_t r;
      r.st = 0; r.x = CX; r.y = CY; r.vx = STEP; r.vy = STEP;
      r.score = 0; r.lives = NLIVES; r.cnt = 0; r.serve = 0;
      r.start_prev = 0; r.miss = 0; r.pix = 0; r.ticks = 0;
      return r;
   endfunction

   function automatic mdl_t mstep(mdl_t c, int st_in, int py, int px_i, int py_i);
      mdl_t n;
      int x1, y1, vx, vy;
      bit tk, rise;
      n    = c;
      tk   = (c.cnt == TDIV - 1);
      rise = (st_in != 0) && (c.start_prev == 0);
      n.cnt = tk ? 0 : c.cnt + 1;
      n.start_prev = st_in;
      n.miss = 0;
      if (tk) n.ticks = c.ticks + 1;
      n.pix = (c.st != 0 && px_i >= c.x && px_i < c.x + BS &&
               py_i >= c.y && py_i < c.y + BS) ? 1 : 0;
      case (c.st)
         0: begin
            n.x = CX; n.y = CY;
            if (rise) begin n.score = 0; n.lives = NLIVES; n.serve = 0; n.st = 1; end
         end
         1: begin
            n.x = CX; n.y = CY; n.vx = STEP; n.vy = STEP;
            if (st_in == 0) n.st = 0;
            else if (tk) begin
               n.serve = c.serve + 1;
               if (n.serve == NSERVE) n.st = 2;
            end
         end
         2: begin
            if (st_in == 0) begin
               n.st = 0; n.x = CX; n.y = CY;
            end else if (tk) begin
               x1 = c.x + c.vx; y1 = c.y + c.vy; vx = c.vx; vy = c.vy;
               if (c.vy < 0 && c.y < STEP) begin y1 = 0; vy = STEP; end
               if (c.vy > 0 && y1 + BS >= VA) begin y1 = VA - BS; vy = -STEP; end
               if (c.vx < 0 && c.x < STEP) begin x1 = 0; vx = STEP; end
               if (c.vx > 0 && c.x + BS < PAD_X && x1 + BS >= PAD_X &&
                   y1 < py + PAD_H && y1 + BS > py) begin
                  x1 = PAD_X - BS; vx = -STEP;
                  n.score = (c.score < 255) ? c.score + 1 : 255;
               end
               if (vx > 0 && x1 + BS >= HA) begin
                  n.miss = 1; n.x = CX; n.y = CY; n.serve = 0;
                  n.lives = c.lives - 1;
                  n.st = (c.lives > 1) ? 1 : 3;
               end else begin
                  n.x = x1; n.y = y1; n.vx = vx; n.vy = vy;
               end
            end
         end
         default: begin
            n.x = CX; n.y = CY;
            if (st_in == 0) n.st = 0;
         end
      endcase
      return n;
   endfunction

   always @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) m <= mreset();
      else m <= mstep(m, int'(start), int'(paddle_y), int'(pix_x), int'(pix_y));
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic lockstep();
      if (failures >= 20) return;
      checks++;
      if (int'(state) != m.st || int'(ball_x) != m.x || int'(ball_y) != m.y ||
          int'(score) != m.score || int'(lives) != m.lives ||
          int'(miss) != m.miss || int'(ball_pix) != m.pix) begin
         failures++;
         $display("FAIL lockstep @%0t: dut st=%0d x=%0d y=%0d sc=%0d lv=%0d miss=%0d pix=%0d model st=%0d x=%0d y=%0d sc=%0d lv=%0d miss=%0d pix=%0d",
                  $time, state, ball_x, ball_y, score, lives, miss, ball_pix,
                  m.st, m.x, m.y, m.score, m.lives, m.miss, m.pix);
      end
   endtask

   task automatic cycle();
      @(posedge vga_clk);
      @(negedge vga_clk);
      lockstep();
   endtask

   task automatic wait_ticks(input int n);
      int target, guard;
      target = m.ticks + n;
      guard  = 0;
      while (m.ticks < target && guard < n * TDIV + 10) begin
         cycle();
         guard++;
      end
      chk("tick_wait_bound", (m.ticks >= target) ? 1 : 0, 1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, int'(state), 0);
      chk({tag, "_x"}, int'(ball_x), CX);
      chk({tag, "_y"}, int'(ball_y), CY);
      chk({tag, "_score"}, int'(score), 0);
      chk({tag, "_lives"}, int'(lives), NLIVES);
      chk({tag, "_miss"}, int'(miss), 0);
      chk({tag, "_pix"}, int'(ball_pix), 0);
   endtask

   typedef struct {
      string name;
      int    px;
      int    py;
      int    exp_pix;
   } pvec_t;

   pvec_t pv[8];

   initial begin
      int v;
      pv[0] = '{"pix_top_left",     316, 236, 1};
      pv[1] = '{"pix_bottom_right", 323, 243, 1};
      pv[2] = '{"pix_right_out",    324, 236, 0};
      pv[3] = '{"pix_left_out",     315, 240, 0};
      pv[4] = '{"pix_below",        320, 244, 0};
      pv[5] = '{"pix_above",        320, 235, 0};
      pv[6] = '{"pix_centre",       319, 239, 1};
      pv[7] = '{"pix_origin",         0,   0, 0};

      sys_rst_n = 1'b0; start = 1'b0; paddle_y = '0; pix_x = '0; pix_y = '0;
      repeat (3) cycle();
      chk_reset_vals("reset");

      // Serve timing
      sys_rst_n = 1'b1; start = 1'b1;
      cycle();
      chk("serve_entry", int'(state), 1);
      wait_ticks(NSERVE - 1);
      chk("serve_tick59", int'(state), 1);
      wait_ticks(1);
      chk("play_tick60", int'(state), 2);
      chk("play_x", int'(ball_x), CX);
      chk("play_y", int'(ball_y), CY);

      // Bottom bounce
      wait_ticks(118);
      chk("bottom_x", int'(ball_x), 552);
      chk("bottom_y", int'(ball_y), 472);
      wait_ticks(1);
      chk("after_bottom_x", int'(ball_x), 554);
      chk("after_bottom_y", int'(ball_y), 470);

      // Paddle hit
      paddle_y = 12'd380;
      wait_ticks(34);
      chk("hit_x", int'(ball_x), 622);
      chk("hit_y", int'(ball_y), 402);
      chk("hit_score", int'(score), 1);
      wait_ticks(1);
      chk("after_hit_x", int'(ball_x), 620);

      start = 1'b0;
      cycle();
      chk("abort_state", int'(state), 0);
      chk("abort_score_kept", int'(score), 1);
      chk("abort_x", int'(ball_x), CX);
      start = 1'b1;
      cycle();
      chk("restart_state", int'(state), 1);
      chk("restart_score", int'(score), 0);
      chk("restart_lives", int'(lives), 3);

      // Miss
      wait_ticks(NSERVE);
      chk("play2_state", int'(state), 2);
      paddle_y = 12'd205;
      wait_ticks(153);
      chk("nohit_x", int'(ball_x), 622);
      chk("nohit_y", int'(ball_y), 402);
      chk("nohit_score", int'(score), 0);
      wait_ticks(4);
      chk("pre_miss_x", int'(ball_x), 630);
      wait_ticks(1);
      chk("miss_pulse", int'(miss), 1);
      chk("miss_lives", int'(lives), 2);
      chk("miss_state", int'(state), 1);
      chk("miss_x", int'(ball_x), CX);
      chk("miss_y", int'(ball_y), CY);
      cycle();
      chk("miss_one_cycle", int'(miss), 0);

      // Game over
      for (int i = 0; i < 2; i++) begin
         wait_ticks(NSERVE);
         wait_ticks(158);
         chk("miss_n_pulse", int'(miss), 1);
         chk("miss_n_lives", int'(lives), 1 - i);
         chk("miss_n_state", int'(state), (i == 0) ? 1 : 3);
      end
      wait_ticks(5);
      chk("over_state", int'(state), 3);
      chk("over_lives", int'(lives), 0);
      chk("over_x", int'(ball_x), CX);
      start = 1'b0;
      cycle();
      chk("over_to_idle", int'(state), 0);
      start = 1'b1;
      cycle();
      chk("newgame_state", int'(state), 1);
      chk("newgame_lives", int'(lives), 3);
      chk("newgame_score", int'(score), 0);

      // Pixel vectors, ball held at centre during SERVE
      for (int i = 0; i < 8; i++) begin
         pix_x = 12'(pv[i].px);
         pix_y = 12'(pv[i].py);
         cycle();
         chk(pv[i].name, int'(ball_pix), pv[i].exp_pix);
      end
      pix_x = 12'(CX); pix_y = 12'(CY);
      start = 1'b0;
      cycle();
      cycle();
      chk("pix_idle_forced", int'(ball_pix), 0);

      // Asynchronous reset mid-PLAY
      start = 1'b1;
      cycle();
      wait_ticks(NSERVE);
      wait_ticks(10);
      chk("pre_rst_x", int'(ball_x), 336);
      chk("pre_rst_y", int'(ball_y), 256);
      pix_x = 12'd336; pix_y = 12'd256;
      cycle();
      chk("pre_rst_pix", int'(ball_pix), 1);
      @(posedge vga_clk);
      #2 sys_rst_n = 1'b0;
      #1 chk_reset_vals("async_rst");
      repeat (2) cycle();
      sys_rst_n = 1'b1;

      // Randomized play against the model
      start = 1'b0;
      for (int c = 0; c < 8000; c++) begin
         if (start) begin
            if ($urandom_range(0, 1499) == 0) start = 1'b0;
         end else if ($urandom_range(0, 19) == 0) begin
            start = 1'b1;
         end
         if ($urandom_range(0, 39) == 0) begin
            if ($urandom_range(0, 1) == 0) paddle_y = 12'($urandom_range(0, 470));
            else begin
               v = m.y - 30 + int'($urandom_range(0, 40));
               if (v < 0) v = 0;
               paddle_y = 12'(v);
            end
         end
         if ($urandom_range(0, 1) == 1) begin
            pix_x = 12'(m.x + int'($urandom_range(0, 11)) - 2);
            pix_y = 12'(m.y + int'($urandom_range(0, 11)) - 2);
         end else begin
            pix_x = 12'($urandom_range(0, 700));
            pix_y = 12'($urandom_range(0, 520));
         end
         if (c == 4000) sys_rst_n = 1'b0;
         if (c == 4002) sys_rst_n = 1'b1;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
